// File: rtl/barramento_arbitro_if.sv
// barramento_arbitro_if
// Groups the requester-side and bus-control signals of the arbiter.
//   req    : one request bit per port
//   dst    : 3-bit destination index per requester, port k in [3k+2:3k]
//   ctrl_k : bus control for port k (bit0 = read, bit1 = write)
//   ack    : one-cycle pulse, transfer for requester k executing
//   busy   : arbiter is not idle
//   err    : one-cycle pulse, request k rejected (only with ARB_ERR_EN)
// Modports: master = requesters/observer, slave = arbiter.
interface barramento_arbitro_if #(
    parameter int N_PORTAS = 6
);
    logic [N_PORTAS-1:0]   req;
    logic [3*N_PORTAS-1:0] dst;
    logic [1:0]            ctrl_0;
    logic [1:0]            ctrl_1;
    logic [1:0]            ctrl_2;
    logic [1:0]            ctrl_3;
    logic [1:0]            ctrl_4;
    logic [1:0]            ctrl_5;
    logic [N_PORTAS-1:0]   ack;
    logic                  busy;
`ifdef ARB_ERR_EN
    logic [N_PORTAS-1:0]   err;
`endif

    modport master (
        output req, dst,
        input  ctrl_0, ctrl_1, ctrl_2, ctrl_3, ctrl_4, ctrl_5, ack, busy
`ifdef ARB_ERR_EN
        , input err
`endif
    );

    modport slave (
        input  req, dst,
        output ctrl_0, ctrl_1, ctrl_2, ctrl_3, ctrl_4, ctrl_5, ack, busy
`ifdef ARB_ERR_EN
        , output err
`endif
    );
endinterface

// File: rtl/barramento_arbitro.sv
// barramento_arbitro
// Round-robin bus arbiter for 6 ports. IDLE picks a winner starting after
// the last granted port, XFER drives one write/read pair for one cycle,
// REL idles the bus for one cycle. Outputs are registered from the state,
// so controls appear one edge after the state enters XFER.
// Ports:
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : barramento_arbitro_if.slave (req, dst, ctrl_0..5, ack, busy, err)
// Configuration:
//   ARB_ERR_EN defined   : winners with dst>5 or dst==src are rejected with an
//                          err pulse instead of a transfer.
//   ARB_ERR_EN undefined : no err port; such transfers run as-is (dst>5 drives
//                          only the source, dst==src drives 2'b11).
module barramento_arbitro #(
    parameter int N_PORTAS = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    barramento_arbitro_if.slave  bus
);
    localparam int IW = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        REL  = 2'd2
    } estado_t;

    estado_t estado, estado_nxt;

    logic [IW-1:0] ptr, ptr_nxt;
    logic [IW-1:0] src, src_nxt;
    logic [IW-1:0] dst_l, dst_l_nxt;

    logic [N_PORTAS-1:0][IW-1:0] dst_v;
    logic [IW-1:0]               venc;
    logic                        achou;

    logic [N_PORTAS-1:0][1:0] ctrl_q, ctrl_nxt;
    logic [N_PORTAS-1:0]      ack_q, ack_nxt;
    logic                     busy_q;

`ifdef ARB_ERR_EN
    logic                err_l, err_l_nxt;
    logic [N_PORTAS-1:0] err_q, err_nxt;
`endif

    assign dst_v = bus.dst;

    // Round-robin search: first requester at (ptr+1), (ptr+2), ... with wrap.
    always_comb begin
        venc  = '0;
        achou = 1'b0;
        for (int i = 1; i <= N_PORTAS; i++) begin
            if (!achou && bus.req[(int'(ptr) + i) % N_PORTAS]) begin
                achou = 1'b1;
                venc  = IW'((int'(ptr) + i) % N_PORTAS);
            end
        end
    end

    always_comb begin
        estado_nxt = estado;
        ptr_nxt    = ptr;
        src_nxt    = src;
        dst_l_nxt  = dst_l;
`ifdef ARB_ERR_EN
        err_l_nxt  = 1'b0;
`endif
        case (estado)
            IDLE: begin
                if (achou) begin
                    src_nxt   = venc;
                    dst_l_nxt = dst_v[venc];
`ifdef ARB_ERR_EN
                    // Rejected winner still advances the pointer so it
                    // cannot starve the others by retrying.
                    if ((dst_v[venc] > IW'(N_PORTAS - 1)) || (dst_v[venc] == venc)) begin
                        err_l_nxt  = 1'b1;
                        ptr_nxt    = venc;
                        estado_nxt = REL;
                    end else begin
                        estado_nxt = XFER;
                    end
`else
                    estado_nxt = XFER;
`endif
                end
            end
            XFER: begin
                ptr_nxt    = src;
                estado_nxt = REL;
            end
            REL: begin
`ifdef ARB_ERR_EN
                err_l_nxt  = 1'b0;
`endif
                estado_nxt = IDLE;
            end
            default: estado_nxt = IDLE;
        endcase
    end

    // Per-port output decode from the current state; registered below.
    // An out-of-range dst matches no port, and dst==src yields 2'b11.
    for (genvar k = 0; k < N_PORTAS; k++) begin : g_porta
        assign ctrl_nxt[k] = (estado == XFER) ? {src == IW'(k), dst_l == IW'(k)} : 2'b00;
        assign ack_nxt[k]  = (estado == XFER) && (src == IW'(k));
`ifdef ARB_ERR_EN
        assign err_nxt[k]  = (estado == REL) && err_l && (src == IW'(k));
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            estado <= IDLE;
            ptr    <= IW'(N_PORTAS - 1);
            src    <= '0;
            dst_l  <= '0;
            ctrl_q <= '0;
            ack_q  <= '0;
            busy_q <= 1'b0;
`ifdef ARB_ERR_EN
            err_l  <= 1'b0;
            err_q  <= '0;
`endif
        end else begin
            estado <= estado_nxt;
            ptr    <= ptr_nxt;
            src    <= src_nxt;
            dst_l  <= dst_l_nxt;
            ctrl_q <= ctrl_nxt;
            ack_q  <= ack_nxt;
            // Tracks the state register exactly: high in XFER and REL.
            busy_q <= (estado_nxt != IDLE);
`ifdef ARB_ERR_EN
            err_l  <= err_l_nxt;
            err_q  <= err_nxt;
`endif
        end
    end

    assign bus.ctrl_0 = ctrl_q[0];
    assign bus.ctrl_1 = ctrl_q[1];
    assign bus.ctrl_2 = ctrl_q[2];
    assign bus.ctrl_3 = ctrl_q[3];
    assign bus.ctrl_4 = ctrl_q[4];
    assign bus.ctrl_5 = ctrl_q[5];
    assign bus.ack    = ack_q;
    assign bus.busy   = busy_q;
`ifdef ARB_ERR_EN
    assign bus.err    = err_q;
`endif
endmodule

// File: tb/tb_barramento_arbitro.sv
module tb_barramento_arbitro;
    logic clk;
    logic rst_n;
    int   ciclo;
    int   checks;
    int   errors;

    typedef struct {
        int              ciclo;
        logic [5:0]      ack;
        logic [5:0][1:0] ctrl;
        logic [5:0]      err;
    } exp_t;

    exp_t fila[$];

    barramento_arbitro_if #(.N_PORTAS(6)) bus ();

    barramento_arbitro #(.N_PORTAS(6)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial ciclo = 0;
    always @(posedge clk) ciclo <= ciclo + 1;

    function automatic logic [11:0] ctrl_all();
        return {bus.ctrl_5, bus.ctrl_4, bus.ctrl_3, bus.ctrl_2, bus.ctrl_1, bus.ctrl_0};
    endfunction

    function automatic logic [5:0] err_all();
`ifdef ARB_ERR_EN
        return bus.err;
`else
        return 6'b0;
`endif
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_dst(input int k, input int v);
        bus.dst[3*k +: 3] = 3'(v);
    endtask

    task automatic reinicia();
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        tick(1);
    endtask

    task automatic verifica(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
        checks++;
        if (atual !== esperado) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nome, atual, esperado);
        end
    endtask

    // Expected bus activity for a grant of port s towards d, visible at cycle c.
    task automatic espera(input int c, input int s, input int d);
        exp_t e;
        e.ciclo = c;
        e.ack   = '0;
        e.ctrl  = '0;
        e.err   = '0;
`ifdef ARB_ERR_EN
        if (d > 5 || d == s) begin
            e.err[s] = 1'b1;
        end else begin
            e.ack[s]  = 1'b1;
            e.ctrl[s] = 2'b10;
            e.ctrl[d] = 2'b01;
        end
`else
        e.ack[s]     = 1'b1;
        e.ctrl[s][1] = 1'b1;
        if (d < 6) e.ctrl[d][0] = 1'b1;
`endif
        fila.push_back(e);
    endtask

    // Monitor: any bus activity must match the next expected entry.
    always @(negedge clk) begin : monitor
        logic [11:0] ac;
        logic [5:0]  ak;
        logic [5:0]  ae;
        exp_t        e;
        ac = ctrl_all();
        ak = bus.ack;
        ae = err_all();
        if (ac != '0 || ak != '0 || ae != '0) begin
            checks++;
            if (fila.size() == 0) begin
                errors++;
                $display("FAIL xfer_inesperada: ciclo=%0d ack=%b ctrl=%b err=%b", ciclo, ak, ac, ae);
            end else begin
                e = fila.pop_front();
                if (e.ciclo != ciclo || e.ack !== ak || e.ctrl !== ac || e.err !== ae) begin
                    errors++;
                    $display("FAIL xfer: got ciclo=%0d ack=%b ctrl=%b err=%b expected ciclo=%0d ack=%b ctrl=%b err=%b",
                             ciclo, ak, ac, ae, e.ciclo, e.ack, e.ctrl, e.err);
                end
            end
        end
    end

    initial begin
        int c;
        checks = 0;
        errors = 0;
        rst_n    = 1'b0;
        bus.req  = '0;
        bus.dst  = '0;
        tick(3);
        verifica("rst_ctrl", 32'(ctrl_all()), 32'h0);
        verifica("rst_ack",  32'(bus.ack), 32'h0);
        verifica("rst_busy", 32'(bus.busy), 32'h0);
        verifica("rst_err",  32'(err_all()), 32'h0);
        rst_n = 1'b1;
        tick(2);
        verifica("idle_busy", 32'(bus.busy), 32'h0);

        // Single request, port 0 -> 4; busy over XFER and REL.
        set_dst(0, 4);
        bus.req = 6'b000001;
        c = ciclo;
        espera(c + 2, 0, 4);
        tick(1);
        verifica("busy_xfer", 32'(bus.busy), 32'h1);
        bus.req = '0;
        tick(1);
        verifica("busy_rel", 32'(bus.busy), 32'h1);
        tick(1);
        verifica("busy_idle", 32'(bus.busy), 32'h0);
        tick(2);

        // Four held requests: 0,1,2,3 then 0 again, 3 cycles apart.
        reinicia();
        for (int k = 0; k < 4; k++) set_dst(k, 4);
        bus.req = 6'b001111;
        c = ciclo;
        espera(c + 2,  0, 4);
        espera(c + 5,  1, 4);
        espera(c + 8,  2, 4);
        espera(c + 11, 3, 4);
        espera(c + 14, 0, 4);
        tick(13);
        bus.req = '0;
        tick(5);

        // After port 3 wins, 3 and 0 together: 0 wins by wrap.
        reinicia();
        set_dst(3, 1);
        bus.req = 6'b001000;
        c = ciclo;
        espera(c + 2, 3, 1);
        tick(1);
        bus.req = '0;
        tick(3);
        set_dst(0, 2);
        bus.req = 6'b001001;
        c = ciclo;
        espera(c + 2, 0, 2);
        tick(1);
        bus.req = '0;
        tick(4);

        // Reset during XFER aborts the transfer and restores ptr=5.
        reinicia();
        set_dst(2, 3);
        bus.req = 6'b000100;
        tick(1);
        rst_n = 1'b0;
        bus.req = '0;
        tick(1);
        verifica("abort_ctrl", 32'(ctrl_all()), 32'h0);
        verifica("abort_ack",  32'(bus.ack), 32'h0);
        verifica("abort_busy", 32'(bus.busy), 32'h0);
        rst_n = 1'b1;
        tick(3);
        set_dst(1, 2);
        set_dst(3, 0);
        bus.req = 6'b001010;
        c = ciclo;
        espera(c + 2, 1, 2);
        tick(1);
        bus.req = '0;
        tick(4);

        // Out-of-range destination, then destination equal to source.
        set_dst(1, 7);
        bus.req = 6'b000010;
        c = ciclo;
        espera(c + 2, 1, 7);
        tick(1);
        bus.req = '0;
        tick(4);
        set_dst(2, 2);
        bus.req = 6'b000100;
        c = ciclo;
        espera(c + 2, 2, 2);
        tick(1);
        bus.req = '0;
        tick(4);

        // dst changed during XFER is ignored.
        set_dst(0, 4);
        bus.req = 6'b000001;
        c = ciclo;
        espera(c + 2, 0, 4);
        tick(1);
        set_dst(0, 5);
        bus.req = '0;
        tick(4);

        // Ports 0 and 5 held: 0 first after reset, then 5.
        reinicia();
        set_dst(0, 5);
        set_dst(5, 0);
        bus.req = 6'b100001;
        c = ciclo;
        espera(c + 2, 0, 5);
        espera(c + 5, 5, 0);
        tick(4);
        bus.req = '0;
        tick(5);

        verifica("fila_vazia", 32'(fila.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/barramento_arbitro.md
BARRAMENTO_ARBITRO -- requirements
Module: barramento_arbitro

Interface
REQ-001 SHALL have parameter N_PORTAS, default 6; number of bus ports arbitrated (fixed at 6 for this revision).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; synchronous, active-low.
REQ-004 SHALL have port req  input  6  req[k]=1: port k requests to write its data onto the bus.
REQ-005 SHALL have port dst  input  18  dst[3k+2:3k] = destination port index for requester k.
REQ-006 SHALL have ports ctrl_0..ctrl_5  output  2 each  bus port controls; bit0 = read, bit1 = write.
REQ-007 SHALL have port ack  output  6  ack[k]: one-cycle pulse, transfer for requester k executing this cycle.
REQ-008 SHALL have port busy  output  1  high while state is not IDLE.
REQ-009 SHALL have port err  output  6  one-cycle pulse, request k rejected (present only with ARB_ERR_EN).

Function
REQ-010 SHALL implement FSM states IDLE, XFER and REL; the state register and all outputs SHALL be registered.
REQ-011 IDLE: if req != 0, SHALL select a winner round-robin, searching from index (ptr+1) mod 6 upward with wrap; latch src=winner and dst of winner; go to XFER. If req == 0, SHALL stay in IDLE.
REQ-012 XFER (exactly 1 cycle): SHALL drive ctrl_src=2'b10, ctrl_dst=2'b01, ack[src]=1, all other ctrl=2'b00; SHALL set ptr=src; next state REL.
REQ-013 REL (exactly 1 cycle): SHALL drive all ctrl=2'b00 and ack=0; next state IDLE.
REQ-014 SHALL have latency: req[k] sampled high at edge n in IDLE gives ctrl/ack visible after edge n+1. Throughput is one transfer per 3 cycles.
REQ-015 Requester SHALL drop req[k] in the cycle after ack[k]; a req still high in IDLE after REL SHALL be treated as a new request.
REQ-016 Changes to req/dst during XFER or REL SHALL be ignored; latched src/dst SHALL be used.
REQ-017 Simultaneous requests: exactly one grant per XFER; no port SHALL wait more than 5 transfers while holding req.
REQ-018 Outside XFER: all ctrl_k SHALL be 2'b00, ack SHALL be 0; busy=1 in XFER and REL.

Reset
REQ-019 With rst_n=0 at an edge: state=IDLE, ptr=5 (port 0 wins first), all ctrl=2'b00, ack=0, busy=0, err=0.
REQ-020 Reset asserted during XFER or REL SHALL abort the transfer at that edge; no ack SHALL follow.

Configuration
REQ-021 Macro ARB_ERR_EN defined: a winner with dst>5 or dst==src SHALL NOT enter XFER; it SHALL pulse err[winner] for 1 cycle, update ptr=winner, go to REL.
REQ-022 Macro ARB_ERR_EN undefined: err port SHALL be absent; dst>5 SHALL execute XFER with only ctrl_src=2'b10; dst==src SHALL drive ctrl_src=2'b11.

Verification
REQ-023 Reset, then req=6'b000001, dst_0=4 -> after 2 edges ctrl_0=2'b10, ctrl_4=2'b01, ack=6'b000001 for 1 cycle; all ctrl 0 next cycle.
REQ-024 req=6'b001111 held, dsts=4 -> grants in order 0,1,2,3 with 3-cycle spacing; then 0 again.
REQ-025 After grant to port 3, req=6'b001001 -> port 0 wins (wrap), not port 3.
REQ-026 rst_n=0 at the XFER cycle for req_2 -> ctrl all 0 and ack=0 next cycle; state IDLE; ptr=5.
REQ-027 ARB_ERR_EN: req_1 with dst_1=7 -> err=6'b000010 pulse, no ctrl activity; without macro ctrl_1=2'b10 only.
REQ-028 dst_0 changed 4->5 during XFER -> transfer still drives ctrl_4; ctrl_5 stays 2'b00.
